// File: rtl/unsign_add_sub_pipe.sv
// unsign_add_sub_pipe: two-stage valid/ready pipeline computing unsigned
// add/subtract on the operands or against an internal accumulator, with
// optional saturation and a carry/borrow flag from the unclamped operation.
module unsign_add_sub_pipe #(
   parameter int INPUT_BIT_WIDTH = 8,
   parameter int ACC_ENABLE      = 1
) (
   input  logic                       Clk,
   input  logic                       ResetN,
   input  logic                       InValid,
   output logic                       InReady,
   input  logic [INPUT_BIT_WIDTH-1:0] InputA,
   input  logic [INPUT_BIT_WIDTH-1:0] InputB,
   input  logic [1:0]                 Mode,
   input  logic                       Saturate,
   input  logic                       AccClear,
   output logic                       OutValid,
   input  logic                       OutReady,
   output logic [INPUT_BIT_WIDTH-1:0] Result,
   output logic                       CarryBorrow,
   output logic [INPUT_BIT_WIDTH-1:0] AccValue
);

   localparam int W = INPUT_BIT_WIDTH;

   // Stage 1 payload
   logic         s1Valid;
   logic [W-1:0] s1A;
   logic [W-1:0] s1B;
   logic [1:0]   s1Mode;
   logic         s1Sat;

   // Stage 2 valid and accumulator
   logic         s2Valid;
   logic [W-1:0] accReg;

   // Handshake and arithmetic intermediates
   logic         s2Advance;
   logic         s1Transfer;
   logic         inAccept;
   logic [W-1:0] accRead;
   logic [W-1:0] base;
   logic [W-1:0] operand;
   logic         isSub;
   logic [W:0]   full;
   logic [W-1:0] nextResult;
   logic         nextCb;

   // Pipeline advance conditions; InReady never looks at InValid
   always_comb begin
      s2Advance  = !s2Valid || OutReady;
      InReady    = !s1Valid || s2Advance;
      inAccept   = InValid && InReady;
      s1Transfer = s1Valid && s2Advance;
   end

   // Stage 2 datapath: W+1 bit add/sub, MSB is carry/borrow, optional clamp
   always_comb begin
      accRead = (ACC_ENABLE != 0) ? accReg : '0;
      if (s1Mode[1]) begin
         base    = accRead;
         operand = s1A;
      end else begin
         base    = s1A;
         operand = s1B;
      end
      isSub = s1Mode[0];
      if (isSub) begin
         full = {1'b0, base} - {1'b0, operand};
      end else begin
         full = {1'b0, base} + {1'b0, operand};
      end
      nextCb = full[W];
      if (s1Sat && nextCb) begin
         nextResult = isSub ? '0 : '1;
      end else begin
         nextResult = full[W-1:0];
      end
   end

   // Stage 1 register: capture operands on accept, hold payload while stalled
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         s1Valid <= 1'b0;
         s1A     <= '0;
         s1B     <= '0;
         s1Mode  <= '0;
         s1Sat   <= 1'b0;
      end else if (InReady) begin
         s1Valid <= InValid;
         if (InValid) begin
            s1A    <= InputA;
            s1B    <= InputB;
            s1Mode <= Mode;
            s1Sat  <= Saturate;
         end
      end
   end

   // Stage 2 register: registered result, held until consumed downstream
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         s2Valid     <= 1'b0;
         Result      <= '0;
         CarryBorrow <= 1'b0;
      end else if (s2Advance) begin
         s2Valid <= s1Valid;
         if (s1Valid) begin
            Result      <= nextResult;
            CarryBorrow <= nextCb;
         end
      end
   end

   // Accumulator: written back on the S1->S2 transfer edge so accumulate
   // beats chain; a same-edge clear wins while the beat saw the old value
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         accReg <= '0;
      end else if (AccClear) begin
         accReg <= '0;
      end else if ((ACC_ENABLE != 0) && s1Transfer && s1Mode[1]) begin
         accReg <= nextResult;
      end
   end

   assign OutValid = s2Valid;
   assign AccValue = accReg;

   // inAccept is kept for readability of the handshake; tie it off here
   logic unusedAccept;
   assign unusedAccept = inAccept;

endmodule
